// File: rtl/exc_pkg.sv
// Shared exception-controller definitions: cause codes, exc_flags_m bit
// positions, FSM state encoding and the selected-cause record.
package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;
  localparam logic [4:0] EXC_ERET = 5'h1f;

  localparam int N_FLAGS       = 14;
  localparam int F_PC_ERR      = 13;
  localparam int F_ITLB_REFILL = 12;
  localparam int F_ITLB_INV    = 11;
  localparam int F_RI          = 10;
  localparam int F_OV          = 9;
  localparam int F_TRAP        = 8;
  localparam int F_SYS         = 7;
  localparam int F_BRK         = 6;
  localparam int F_ADEL        = 5;
  localparam int F_ADES        = 4;
  localparam int F_DTLB_REFILL = 3;
  localparam int F_DTLB_INV    = 2;
  localparam int F_DTLB_MOD    = 1;
  localparam int F_ERET        = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_e;

  typedef struct packed {
    logic       vld;
    logic [4:0] code;
    logic       badv_we;
    logic       badv_pc;   // badvaddr comes from pc_m rather than mem_addr_m
    logic       refill;    // vector to base+0 instead of base+0x180
    logic       eret;
  } exc_sel_t;

endpackage

// File: rtl/int_sync.sv
// One-bit multi-flop synchroniser for an asynchronous level input.
module int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_chain <= '0;
    else         r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/exception_ctrl.sv
// M-stage exception/interrupt arbiter: picks the highest-priority cause,
// then runs a flush -> CP0 update -> fetch redirect sequence.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int          N_HWINT     = 6,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BEV_BASE    = 32'hbfc0_0200
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_HWINT-1:0]   hw_int,
  input  logic                 valid_m,
  input  logic                 stall_m,
  input  logic [31:0]          pc_m,
  input  logic [31:0]          mem_addr_m,
  input  logic                 in_ds_m,
  input  logic [N_FLAGS-1:0]   exc_flags_m,
  input  logic                 mem_rd_m,
  input  logic                 mem_wr_m,
  input  logic [31:0]          cp0_status,
  input  logic [31:0]          cp0_cause,
  input  logic [31:0]          cp0_epc,
  input  logic [31:0]          cp0_ebase,
  output logic                 flush,
  output logic                 redirect_valid,
  input  logic                 redirect_ready,
  output logic [31:0]          redirect_pc,
  output logic                 cp0_wr,
  output logic [4:0]           cp0_exccode,
  output logic [31:0]          cp0_epc_o,
  output logic [31:0]          cp0_badvaddr,
  output logic                 cp0_bd,
  output logic                 cp0_badv_we,
  output logic                 cp0_eret,
  output logic [N_HWINT-1:0]   ip_hw
);

  exc_state_e  r_state, w_next;
  exc_sel_t    w_sel;
  logic [5:0]  w_hw6;
  logic [7:0]  w_pend_vec;
  logic        w_int_pend, w_dtlb, w_take;
  logic [31:0] w_epc, w_base, w_target;

  logic [4:0]  r_code;
  logic [31:0] r_epc, r_badv, r_target;
  logic        r_bd, r_badv_we, r_eret;

  for (genvar g = 0; g < N_HWINT; g++) begin : g_sync
    int_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .i_d    (hw_int[g]),
      .o_q    (ip_hw[g])
    );
  end

  always_comb begin
    w_hw6                = '0;
    w_hw6[N_HWINT-1:0]   = ip_hw;
  end

  // Status: IE=0, EXL=1, ERL=2, IM=15:8, BEV=22. Cause.IP1..0 = 9:8.
  assign w_pend_vec = cp0_status[15:8] & {w_hw6, cp0_cause[9:8]};
  assign w_int_pend = cp0_status[0] & ~cp0_status[1] & ~cp0_status[2] & (|w_pend_vec);
  assign w_dtlb     = exc_flags_m[F_DTLB_REFILL] | exc_flags_m[F_DTLB_INV];

  always_comb begin
    w_sel = '0;
    if (w_int_pend) begin
      w_sel.vld = 1'b1; w_sel.code = EXC_INT;
    end else if (exc_flags_m[F_PC_ERR]) begin
      w_sel.vld = 1'b1; w_sel.code = EXC_ADEL; w_sel.badv_we = 1'b1; w_sel.badv_pc = 1'b1;
    end else if (exc_flags_m[F_ITLB_REFILL] | exc_flags_m[F_ITLB_INV]) begin
      w_sel.vld = 1'b1; w_sel.code = EXC_TLBL; w_sel.badv_we = 1'b1; w_sel.badv_pc = 1'b1;
      w_sel.refill = exc_flags_m[F_ITLB_REFILL];
    end else if (exc_flags_m[F_RI]) begin
      w_sel.vld = 1'b1; w_sel.code = EXC_RI;
    end else if (exc_flags_m[F_OV]) begin
      w_sel.vld = 1'b1; w_sel.code = EXC_OV;
    end else if (exc_flags_m[F_TRAP]) begin
      w_sel.vld = 1'b1; w_sel.code = EXC_TR;
    end else if (exc_flags_m[F_SYS]) begin
      w_sel.vld = 1'b1; w_sel.code = EXC_SYS;
    end else if (exc_flags_m[F_BRK]) begin
      w_sel.vld = 1'b1; w_sel.code = EXC_BP;
    end else if (exc_flags_m[F_ADEL]) begin
      w_sel.vld = 1'b1; w_sel.code = EXC_ADEL; w_sel.badv_we = 1'b1;
    end else if (exc_flags_m[F_ADES]) begin
      w_sel.vld = 1'b1; w_sel.code = EXC_ADES; w_sel.badv_we = 1'b1;
    end else if (w_dtlb & (mem_rd_m | mem_wr_m)) begin
      // A data TLB miss without a real access is spurious and ignored.
      w_sel.vld = 1'b1; w_sel.code = mem_rd_m ? EXC_TLBL : EXC_TLBS; w_sel.badv_we = 1'b1;
      w_sel.refill = exc_flags_m[F_DTLB_REFILL] & ~cp0_status[1];
    end else if (exc_flags_m[F_DTLB_MOD]) begin
      w_sel.vld = 1'b1; w_sel.code = EXC_MOD; w_sel.badv_we = 1'b1;
    end else if (exc_flags_m[F_ERET]) begin
      w_sel.vld = 1'b1; w_sel.code = EXC_ERET; w_sel.eret = 1'b1;
    end
  end

  assign w_take   = valid_m & ~stall_m & (r_state == ST_IDLE) & w_sel.vld;
  assign w_epc    = in_ds_m ? pc_m - 32'd4 : pc_m;
  assign w_base   = cp0_status[22] ? BEV_BASE : cp0_ebase;
  assign w_target = w_sel.eret   ? cp0_epc :
                    w_sel.refill ? w_base  : w_base + 32'h180;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_take) w_next = ST_FLUSH;
      ST_FLUSH:    w_next = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    flush          = 1'b0;
    cp0_wr         = 1'b0;
    cp0_eret       = 1'b0;
    cp0_badv_we    = 1'b0;
    redirect_valid = 1'b0;
    case (r_state)
      ST_FLUSH: begin
        flush       = 1'b1;
        cp0_wr      = ~r_eret;
        cp0_eret    = r_eret;
        cp0_badv_we = ~r_eret & r_badv_we;
      end
      ST_REDIRECT: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_code    <= '0;
      r_epc     <= '0;
      r_badv    <= '0;
      r_target  <= '0;
      r_bd      <= 1'b0;
      r_badv_we <= 1'b0;
      r_eret    <= 1'b0;
    end else if (w_take) begin
      r_code    <= w_sel.code;
      r_epc     <= w_epc;
      r_badv    <= w_sel.badv_pc ? pc_m : mem_addr_m;
      r_target  <= w_target;
      r_bd      <= in_ds_m;
      r_badv_we <= w_sel.badv_we;
      r_eret    <= w_sel.eret;
    end
  end

  assign cp0_exccode  = r_code;
  assign cp0_epc_o    = r_epc;
  assign cp0_badvaddr = r_badv;
  assign cp0_bd       = r_bd;
  assign redirect_pc  = r_target;

  logic w_unused_bits;
  assign w_unused_bits = ^{cp0_status[31:23], cp0_status[21:16], cp0_status[7:3],
                           cp0_cause[31:10], cp0_cause[7:0]};

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: spec-level model checked every cycle plus
// directed scenarios with literal expected values.
module tb_exception_ctrl;
  import exc_pkg::*;

  localparam int          NH   = 6;
  localparam int          SS   = 2;
  localparam logic [31:0] BEVB = 32'hbfc0_0200;

  logic              clk = 1'b0, resetn = 1'b0;
  logic [NH-1:0]     hw_int = '0;
  logic              valid_m = 0, stall_m = 0, in_ds_m = 0, mem_rd_m = 0, mem_wr_m = 0;
  logic [31:0]       pc_m = '0, mem_addr_m = '0;
  logic [13:0]       exc_flags_m = '0;
  logic [31:0]       cp0_status = '0, cp0_cause = '0;
  logic [31:0]       cp0_epc = 32'hbfc0_1000, cp0_ebase = 32'h8000_0000;
  logic              redirect_ready = 0;
  logic              flush, redirect_valid, cp0_wr, cp0_bd, cp0_badv_we, cp0_eret;
  logic [31:0]       redirect_pc, cp0_epc_o, cp0_badvaddr;
  logic [4:0]        cp0_exccode;
  logic [NH-1:0]     ip_hw;

  always #5 clk = ~clk;

  exception_ctrl #(.N_HWINT(NH), .SYNC_STAGES(SS), .BEV_BASE(BEVB)) dut (
    .clk(clk), .resetn(resetn), .hw_int(hw_int), .valid_m(valid_m), .stall_m(stall_m),
    .pc_m(pc_m), .mem_addr_m(mem_addr_m), .in_ds_m(in_ds_m), .exc_flags_m(exc_flags_m),
    .mem_rd_m(mem_rd_m), .mem_wr_m(mem_wr_m), .cp0_status(cp0_status), .cp0_cause(cp0_cause),
    .cp0_epc(cp0_epc), .cp0_ebase(cp0_ebase), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .cp0_wr(cp0_wr),
    .cp0_exccode(cp0_exccode), .cp0_epc_o(cp0_epc_o), .cp0_badvaddr(cp0_badvaddr),
    .cp0_bd(cp0_bd), .cp0_badv_we(cp0_badv_we), .cp0_eret(cp0_eret), .ip_hw(ip_hw)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Priority-ordered rule table: the first matching rule wins.
  function automatic void classify(input logic [13:0] f, input logic rd, input logic wr,
                                   input logic [31:0] st, input bit intp,
                                   output bit hit, output logic [4:0] code, output bit bwe,
                                   output bit use_pc, output bit refill, output bit er);
    bit         cond [14];
    logic [4:0] cd   [14];
    bit         dt;
    dt   = f[F_DTLB_REFILL] | f[F_DTLB_INV];
    cond = '{intp, f[F_PC_ERR], f[F_ITLB_REFILL] | f[F_ITLB_INV], f[F_RI], f[F_OV],
             f[F_TRAP], f[F_SYS], f[F_BRK], f[F_ADEL], f[F_ADES], dt & rd, dt & wr,
             f[F_DTLB_MOD], f[F_ERET]};
    cd   = '{5'd0, 5'd4, 5'd2, 5'd10, 5'd12, 5'd13, 5'd8, 5'd9, 5'd4, 5'd5, 5'd2, 5'd3,
             5'd1, 5'h1f};
    hit = 0; code = '0; bwe = 0; use_pc = 0; refill = 0; er = 0;
    for (int i = 0; i < 14; i++) begin
      if (!hit && cond[i]) begin
        hit    = 1;
        code   = cd[i];
        bwe    = (i == 1) || (i == 2) || (i >= 8 && i <= 12);
        use_pc = (i == 1) || (i == 2);
        refill = (i == 2 && f[F_ITLB_REFILL]) ||
                 ((i == 10 || i == 11) && f[F_DTLB_REFILL] && !st[1]);
        er     = (i == 13);
      end
    end
  endfunction

  // Model state: phase 0 idle, 1 flush cycle, 2 waiting for redirect accept.
  int          m_ph;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_badv, m_tgt;
  logic        m_bd, m_bwe, m_eret;
  logic [NH-1:0] m_hist [SS];
  logic [NH-1:0] m_ip;
  assign m_ip = m_hist[SS-1];

  always @(posedge clk or negedge resetn) begin : model
    bit hit, bwe, use_pc, refill, er, intp;
    logic [4:0] code;
    logic [7:0] pend;
    logic [31:0] base;
    if (!resetn) begin
      m_ph <= 0; m_code <= '0; m_epc <= '0; m_badv <= '0; m_tgt <= '0;
      m_bd <= 0; m_bwe <= 0; m_eret <= 0;
      for (int i = 0; i < SS; i++) m_hist[i] <= '0;
    end else begin
      pend = cp0_status[15:8] & {m_ip, cp0_cause[9:8]};
      intp = cp0_status[0] && !cp0_status[1] && !cp0_status[2] && (pend != 0);
      classify(exc_flags_m, mem_rd_m, mem_wr_m, cp0_status, intp, hit, code, bwe, use_pc, refill, er);
      base = cp0_status[22] ? BEVB : cp0_ebase;
      if (m_ph == 0) begin
        if (valid_m && !stall_m && hit) begin
          m_ph   <= 1;
          m_code <= code;
          m_epc  <= in_ds_m ? pc_m - 32'd4 : pc_m;
          m_bd   <= in_ds_m;
          m_badv <= use_pc ? pc_m : mem_addr_m;
          m_bwe  <= bwe;
          m_eret <= er;
          m_tgt  <= er ? cp0_epc : base + (refill ? 32'h0 : 32'h180);
        end
      end else if (m_ph == 1) m_ph <= 2;
      else if (redirect_ready) m_ph <= 0;
      m_hist[0] <= hw_int;
      for (int i = 1; i < SS; i++) m_hist[i] <= m_hist[i-1];
    end
  end

  always @(negedge clk) begin : compare
    chk("m.flush", flush, m_ph != 0);
    chk("m.rvalid", redirect_valid, m_ph == 2);
    chk("m.cp0_wr", cp0_wr, m_ph == 1 && !m_eret);
    chk("m.cp0_eret", cp0_eret, m_ph == 1 && m_eret);
    chk("m.badv_we", cp0_badv_we, m_ph == 1 && !m_eret && m_bwe);
    chk("m.ip_hw", ip_hw, m_ip);
    if (m_ph == 1) begin
      chk("m.code", cp0_exccode, m_code);
      if (!m_eret) begin
        chk("m.epc", cp0_epc_o, m_epc);
        chk("m.bd", cp0_bd, m_bd);
        if (m_bwe) chk("m.badv", cp0_badvaddr, m_badv);
      end
    end
    if (m_ph == 2) chk("m.rpc", redirect_pc, m_tgt);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [13:0] fl(input int b);
    logic [13:0] v;
    v = '0; v[b] = 1'b1;
    return v;
  endfunction

  task automatic run_exc(input string nm, input logic [13:0] f, input logic rd, input logic wr,
                         input logic [31:0] st, input logic [31:0] pc, input logic [31:0] addr,
                         input logic ds, input logic [4:0] e_code, input logic [31:0] e_epc,
                         input logic e_bwe, input logic [31:0] e_badv, input logic [31:0] e_tgt);
    cp0_status = st; exc_flags_m = f; mem_rd_m = rd; mem_wr_m = wr;
    pc_m = pc; mem_addr_m = addr; in_ds_m = ds; valid_m = 1;
    tick;
    chk({nm, ".wr"}, cp0_wr, 1);
    chk({nm, ".code"}, cp0_exccode, e_code);
    chk({nm, ".epc"}, cp0_epc_o, e_epc);
    chk({nm, ".bd"}, cp0_bd, ds);
    chk({nm, ".bwe"}, cp0_badv_we, e_bwe);
    if (e_bwe) chk({nm, ".badv"}, cp0_badvaddr, e_badv);
    valid_m = 0; exc_flags_m = '0; mem_rd_m = 0; mem_wr_m = 0; in_ds_m = 0;
    tick;
    chk({nm, ".rvalid"}, redirect_valid, 1);
    chk({nm, ".rpc"}, redirect_pc, e_tgt);
    redirect_ready = 1;
    tick;
    chk({nm, ".idle"}, flush, 0);
    redirect_ready = 0;
  endtask

  initial begin
    repeat (2) tick;
    chk("rst.flush", flush, 0);
    chk("rst.rvalid", redirect_valid, 0);
    chk("rst.rpc", redirect_pc, 0);
    chk("rst.code", cp0_exccode, 0);
    chk("rst.ip", ip_hw, 0);
    #2 resetn = 1;
    tick;

    run_exc("ov_ds", fl(F_OV), 0, 0, 32'h0, 32'h8000_0104, 32'h0, 1,
            5'd12, 32'h8000_0100, 0, 32'h0, 32'h8000_0180);
    run_exc("tlbs_refill", fl(F_DTLB_REFILL), 0, 1, 32'h0, 32'h8000_0200, 32'h0040_0010, 0,
            5'd3, 32'h8000_0200, 1, 32'h0040_0010, 32'h8000_0000);
    run_exc("tlbl_exl", fl(F_DTLB_REFILL), 1, 0, 32'h2, 32'h8000_0300, 32'h0000_1234, 0,
            5'd2, 32'h8000_0300, 1, 32'h0000_1234, 32'h8000_0180);
    run_exc("pcerr_bev", fl(F_PC_ERR) | fl(F_RI), 0, 0, 32'h0040_0000, 32'h0000_0003, 32'h5, 0,
            5'd4, 32'h0000_0003, 1, 32'h0000_0003, 32'hbfc0_0380);
    run_exc("itlb_refill", fl(F_ITLB_REFILL), 0, 0, 32'h0040_0000, 32'h0040_1000, 32'h0, 0,
            5'd2, 32'h0040_1000, 1, 32'h0040_1000, 32'hbfc0_0200);
    run_exc("itlb_inv", fl(F_ITLB_INV), 0, 0, 32'h0, 32'h0040_2000, 32'h0, 0,
            5'd2, 32'h0040_2000, 1, 32'h0040_2000, 32'h8000_0180);
    run_exc("tr_sys_bp", fl(F_TRAP) | fl(F_SYS) | fl(F_BRK), 0, 0, 32'h0, 32'h8000_0010, 32'h0, 0,
            5'd13, 32'h8000_0010, 0, 32'h0, 32'h8000_0180);
    run_exc("adel_ades", fl(F_ADEL) | fl(F_ADES), 1, 0, 32'h0, 32'h8000_0020, 32'h0000_1001, 0,
            5'd4, 32'h8000_0020, 1, 32'h0000_1001, 32'h8000_0180);
    run_exc("ades", fl(F_ADES), 0, 1, 32'h0, 32'h8000_0024, 32'h0000_1002, 0,
            5'd5, 32'h8000_0024, 1, 32'h0000_1002, 32'h8000_0180);
    run_exc("dtlb_inv_rw", fl(F_DTLB_INV), 1, 1, 32'h0, 32'h8000_0028, 32'h0000_2000, 0,
            5'd2, 32'h8000_0028, 1, 32'h0000_2000, 32'h8000_0180);
    run_exc("mod", fl(F_DTLB_MOD), 0, 1, 32'h0, 32'h8000_002c, 32'h0000_3000, 0,
            5'd1, 32'h8000_002c, 1, 32'h0000_3000, 32'h8000_0180);
    run_exc("bp", fl(F_BRK), 0, 0, 32'h0, 32'h8000_0030, 32'h0, 0,
            5'd9, 32'h8000_0030, 0, 32'h0, 32'h8000_0180);
    run_exc("sys_wrap", fl(F_SYS), 0, 0, 32'h0, 32'h0000_0000, 32'h0, 1,
            5'd8, 32'hffff_fffc, 0, 32'h0, 32'h8000_0180);

    // Data TLB miss with no access qualifier must not trap.
    exc_flags_m = fl(F_DTLB_REFILL); valid_m = 1;
    tick;
    chk("dtlb_noacc.flush", flush, 0);
    valid_m = 0; exc_flags_m = '0;

    // Interrupt latency from the raw line.
    cp0_status = 32'h0000_0401; pc_m = 32'h8000_0040; valid_m = 1; hw_int[0] = 1;
    for (int i = 0; i < SS; i++) begin
      tick;
      chk("int.early", flush, 0);
    end
    tick;
    chk("int.flush", flush, 1);
    chk("int.code", cp0_exccode, 0);
    chk("int.epc", cp0_epc_o, 32'h8000_0040);
    valid_m = 0;
    tick;
    chk("int.rpc", redirect_pc, 32'h8000_0180);
    redirect_ready = 1; tick; redirect_ready = 0;

    // EXL masks the still-pending interrupt until cleared.
    cp0_status = 32'h0000_0403; valid_m = 1;
    repeat (2) begin tick; chk("int_exl.masked", flush, 0); end
    cp0_status = 32'h0000_0401;
    tick;
    chk("int_exl.taken", cp0_wr, 1);
    valid_m = 0; hw_int = '0; cp0_status = 32'h0;
    tick;
    redirect_ready = 1; tick; redirect_ready = 0;
    repeat (SS) tick;

    // ERET with a slow fetch acceptor.
    exc_flags_m = fl(F_ERET); valid_m = 1;
    tick;
    chk("eret.pulse", cp0_eret, 1);
    chk("eret.nowr", cp0_wr, 0);
    valid_m = 0; exc_flags_m = '0;
    repeat (3) begin
      tick;
      chk("eret.rvalid", redirect_valid, 1);
      chk("eret.rpc", redirect_pc, 32'hbfc0_1000);
      chk("eret.once", cp0_eret, 0);
    end
    redirect_ready = 1; tick; redirect_ready = 0;
    chk("eret.done", redirect_valid, 0);

    // Stalled M stage holds off RI+SYS; later events during flush are dropped.
    exc_flags_m = fl(F_RI) | fl(F_SYS); valid_m = 1; stall_m = 1; pc_m = 32'h8000_0050;
    repeat (2) begin tick; chk("stall.hold", flush, 0); end
    stall_m = 0;
    tick;
    chk("stall.code", cp0_exccode, 10);
    exc_flags_m = fl(F_OV);
    tick;
    chk("stall.dropped", cp0_wr, 0);
    redirect_ready = 1; valid_m = 0; exc_flags_m = '0;
    tick;
    chk("stall.idle", flush, 0);
    redirect_ready = 0;

    // Reset in the middle of a redirect.
    exc_flags_m = fl(F_SYS); valid_m = 1; pc_m = 32'h8000_0060;
    tick;
    valid_m = 0; exc_flags_m = '0;
    tick;
    chk("rstmid.pre", redirect_valid, 1);
    #2 resetn = 0;
    #1;
    chk("rstmid.flush", flush, 0);
    chk("rstmid.rvalid", redirect_valid, 0);
    chk("rstmid.rpc", redirect_pc, 0);
    chk("rstmid.code", cp0_exccode, 0);
    chk("rstmid.epc", cp0_epc_o, 0);
    tick;
    #2 resetn = 1;
    repeat (3) begin
      tick;
      chk("rstmid.nowr", cp0_wr, 0);
      chk("rstmid.idle", flush, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 Parameter N_HWINT, 6, number of hardware interrupt lines (1..6), mapped to IP2 upward.
REQ-002 Parameter SYNC_STAGES, 2, flip-flop depth of each hardware-interrupt synchroniser (>=2).
REQ-003 Parameter BEV_BASE, 32'hbfc0_0200, vector base used when Status.BEV=1.
REQ-004 Port clk  in  1  sole clock.
REQ-005 Port resetn  in  1  asynchronous, active-low reset.
REQ-006 Port hw_int  in  N_HWINT  asynchronous level interrupt requests.
REQ-007 Port valid_m, stall_m  in  1 each  M-stage instruction valid; M-stage held this cycle.
REQ-008 Port pc_m, mem_addr_m  in  32 each  M-stage PC; data address.
REQ-009 Port in_ds_m  in  1  M-stage instruction is in a branch delay slot.
REQ-010 Port exc_flags_m  in  14  {pc_err, itlb_refill, itlb_inv, ri, ov, trap, sys, brk, adel, ades, dtlb_refill, dtlb_inv, dtlb_mod, eret}, MSB first.
REQ-011 Port mem_rd_m, mem_wr_m  in  1 each  qualify data-TLB refill/invalid as TLBL or TLBS.
REQ-012 Port cp0_status, cp0_cause, cp0_epc, cp0_ebase  in  32 each  current CP0 values.
REQ-013 Port flush  out  1  flush all stages up to and including M.
REQ-014 Port redirect_valid / redirect_ready  out / in  1 each  fetch redirect handshake.
REQ-015 Port redirect_pc  out  32  target PC.
REQ-016 Port cp0_wr  out  1  one-cycle CP0 update strobe.
REQ-017 Port cp0_exccode, cp0_epc_o, cp0_badvaddr, cp0_bd, cp0_badv_we, cp0_eret  out  5, 32, 32, 1, 1, 1.
REQ-018 Port ip_hw  out  N_HWINT  synchronised lines, for Cause.IP7..IP2.

Function
REQ-019 Each hw_int bit shall pass a SYNC_STAGES flop chain; ip_hw = final stage.
REQ-020 Interrupt pending = Status.IE & ~Status.EXL & ~Status.ERL & |(IM & {ip_hw, Cause.IP1..0}).
REQ-021 Exceptions are taken only when valid_m=1, stall_m=0, state=IDLE.
REQ-022 Priority, highest first: Int, AdEL(pc_err), TLBL(itlb), RI, Ov, Tr, Sys, Bp, AdEL(adel), AdES, TLBL(dtlb & mem_rd_m), TLBS(dtlb & mem_wr_m), Mod, ERET.
REQ-023 Codes: Int 0, Mod 1, TLBL 2, TLBS 3, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12, Tr 13; ERET uses package constant EXC_ERET=5'h1f and performs no Cause write.
REQ-024 dtlb refill/invalid with neither mem_rd_m nor mem_wr_m shall be ignored.
REQ-025 FSM states IDLE, FLUSH, REDIRECT.
REQ-026 IDLE->FLUSH when any exception is taken (REQ-021); selected code, epc, badvaddr, target latched in the same edge.
REQ-027 FLUSH lasts exactly one cycle: flush=1, cp0_wr=1 (exc) or cp0_eret=1 (ERET); next state REDIRECT.
REQ-028 REDIRECT: redirect_valid=1 with stable redirect_pc; on redirect_ready=1 -> IDLE same edge; flush stays 1 throughout REDIRECT.
REQ-029 Target: ERET -> cp0_epc; else base+offset, base = BEV ? BEV_BASE : cp0_ebase, offset = 0 for TLB refill (itlb_refill, or dtlb_refill with Status.EXL=0), else 32'h180.
REQ-030 epc = in_ds_m ? pc_m-4 : pc_m (32-bit wrap); cp0_bd = in_ds_m.
REQ-031 badvaddr = pc_m for pc_err/itlb_*, mem_addr_m for adel/ades/dtlb_*; cp0_badv_we=1 only for those causes.
REQ-032 Events arriving in FLUSH/REDIRECT are dropped (their instructions are flushed); pending interrupts are re-evaluated on return to IDLE.
REQ-033 Latency: exception visible at M edge N -> flush and cp0_wr at cycle N+1; earliest redirect accept N+2.

Reset
REQ-034 resetn=0 shall asynchronously force state=IDLE, synchroniser flops=0, and all outputs 0 (redirect_pc=0, cp0_exccode=0).
REQ-035 Reset asserted in FLUSH/REDIRECT shall abandon the redirect; no cp0_wr is issued after release until a new exception.

Structure
REQ-036 Package exc_pkg holds the exception-code constants, EXC_ERET, FSM state enum, and the exc_flags_m bit indices.
REQ-037 Sub-module int_sync (one-bit parametrised synchroniser), instantiated N_HWINT times.

Verification
REQ-038 ov=1, in_ds_m=1, pc_m=32'h8000_0104, BEV=0, EBase=32'h8000_0000 -> next cycle cp0_exccode=12, epc=32'h8000_0100, bd=1; redirect_pc=32'h8000_0180.
REQ-039 dtlb_refill, mem_wr_m=1, EXL=0, mem_addr_m=32'h0040_0010 -> code 3, badvaddr=32'h0040_0010, redirect_pc=EBase+0.
REQ-040 hw_int[0] rises, IE=1, IM2=1, EXL=0 -> code 0 taken exactly SYNC_STAGES+1 cycles later on a valid non-stalled M.
REQ-041 eret with cp0_epc=32'hbfc0_1000, redirect_ready held 0 for 3 cycles -> cp0_eret pulse once, redirect_valid held 3 cycles, no cp0_wr.
REQ-042 ri and sys together, stall_m=1 for 2 cycles -> nothing until stall drops, then code 10 only.
REQ-043 resetn low during REDIRECT -> all outputs 0 immediately, IDLE after release.
